// File: rtl/gray_to_color_adapter.sv
// gray_to_color_adapter
//   Expands one grayscale pixel per AXI4-Stream beat into CHANNELS colour
//   channels. Three modes are available: replicate, per-channel tint gain
//   (truncating, saturating) and invert. Mode and gains are captured only on
//   an accepted start-of-frame beat (tuser=1), so every frame uses a single
//   configuration. The datapath has two registered stages and full
//   backpressure.
//
// Ports
//   clk_i, rstn_i      clock, synchronous active-low reset
//   mode_i, gain_i     requested configuration (latched on accepted tuser)
//   video_i_*          input stream, pixel in tdata[PX_WIDTH-1:0]
//   video_o_*          output stream, channel c at [c*PX_WIDTH +: PX_WIDTH]
//   active_mode_o      mode currently in effect
module gray_to_color_adapter #(
  parameter int PX_WIDTH       = 10,
  parameter int CHANNELS       = 3,
  parameter int GAIN_WIDTH     = 12,
  parameter int GAIN_FRAC      = 8,
  parameter int RX_TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8,
  parameter int TX_TDATA_WIDTH = ((PX_WIDTH * CHANNELS + 7) / 8) * 8
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [1:0]                     mode_i,
  input  logic [CHANNELS*GAIN_WIDTH-1:0] gain_i,
  input  logic                           video_i_tvalid,
  input  logic [RX_TDATA_WIDTH-1:0]      video_i_tdata,
  input  logic                           video_i_tlast,
  input  logic                           video_i_tuser,
  input  logic [RX_TDATA_WIDTH/8-1:0]    video_i_tstrb,
  input  logic [RX_TDATA_WIDTH/8-1:0]    video_i_tkeep,
  input  logic                           video_i_tdest,
  input  logic                           video_i_tid,
  output logic                           video_i_tready,
  output logic                           video_o_tvalid,
  output logic [TX_TDATA_WIDTH-1:0]      video_o_tdata,
  output logic                           video_o_tlast,
  output logic                           video_o_tuser,
  output logic [TX_TDATA_WIDTH/8-1:0]    video_o_tstrb,
  output logic [TX_TDATA_WIDTH/8-1:0]    video_o_tkeep,
  output logic                           video_o_tdest,
  output logic                           video_o_tid,
  input  logic                           video_o_tready,
  output logic [1:0]                     active_mode_o
);

  localparam int PROD_W = PX_WIDTH + GAIN_WIDTH;
  localparam int GAINS_W = CHANNELS * GAIN_WIDTH;
  localparam int PRODS_W = CHANNELS * PROD_W;

  localparam logic [1:0] MODE_TINT   = 2'd1;
  localparam logic [1:0] MODE_INVERT = 2'd2;

  localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = GAIN_WIDTH'(1) << GAIN_FRAC;
  localparam logic [PX_WIDTH-1:0]   PX_MAX   = '1;
  localparam logic [PROD_W-1:0]     PX_MAX_W = PROD_W'(PX_MAX);

  // Active configuration
  logic [1:0]         mode_q, mode_d;
  logic [GAINS_W-1:0] gain_q, gain_d;

  // Stage 1: pixel, sideband, mode snapshot and raw tint products
  logic                s1_valid_q, s1_valid_d;
  logic [PX_WIDTH-1:0] s1_px_q, s1_px_d;
  logic                s1_last_q, s1_last_d;
  logic                s1_user_q, s1_user_d;
  logic [1:0]          s1_mode_q, s1_mode_d;
  logic [PRODS_W-1:0]  s1_prod_q, s1_prod_d;

  // Stage 2: packed output beat
  logic                      s2_valid_q, s2_valid_d;
  logic [TX_TDATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                      s2_last_q, s2_last_d;
  logic                      s2_user_q, s2_user_d;

  logic en;
  logic accept;
  logic cfg_load;

  // Configuration latch. The start-of-frame beat itself must already see the
  // new configuration, so stage 1 samples mode_d/gain_d rather than the flops.
  always_comb begin
    en       = !s2_valid_q || video_o_tready;
    accept   = video_i_tvalid && en;
    cfg_load = accept && video_i_tuser;
    mode_d   = mode_q;
    gain_d   = gain_q;
    if (cfg_load) begin
      mode_d = mode_i;
      gain_d = gain_i;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_px_d    = s1_px_q;
    s1_last_d  = s1_last_q;
    s1_user_d  = s1_user_q;
    s1_mode_d  = s1_mode_q;
    s1_prod_d  = s1_prod_q;
    if (en) begin
      s1_valid_d = video_i_tvalid;
      s1_px_d    = video_i_tdata[PX_WIDTH-1:0];
      s1_last_d  = video_i_tlast;
      s1_user_d  = video_i_tuser;
      s1_mode_d  = mode_d;
      for (int c = 0; c < CHANNELS; c++) begin
        s1_prod_d[c*PROD_W +: PROD_W] =
          PROD_W'(video_i_tdata[PX_WIDTH-1:0]) * PROD_W'(gain_d[c*GAIN_WIDTH +: GAIN_WIDTH]);
      end
    end
  end

  always_comb begin
    logic [PROD_W-1:0]   shifted;
    logic [PX_WIDTH-1:0] ch;
    shifted    = '0;
    ch         = '0;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_last_d  = s2_last_q;
    s2_user_d  = s2_user_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_user_d  = s1_user_q;
      s2_data_d  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        shifted = s1_prod_q[c*PROD_W +: PROD_W] >> GAIN_FRAC;
        case (s1_mode_q)
          MODE_TINT:   ch = (shifted > PX_MAX_W) ? PX_MAX : shifted[PX_WIDTH-1:0];
          MODE_INVERT: ch = ~s1_px_q;
          default:     ch = s1_px_q;  // replicate, reserved mode 3 included
        endcase
        s2_data_d[c*PX_WIDTH +: PX_WIDTH] = ch;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mode_q     <= '0;
      gain_q     <= {CHANNELS{GAIN_ONE}};
      s1_valid_q <= 1'b0;
      s1_px_q    <= '0;
      s1_last_q  <= 1'b0;
      s1_user_q  <= 1'b0;
      s1_mode_q  <= '0;
      s1_prod_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
      s2_user_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      gain_q     <= gain_d;
      s1_valid_q <= s1_valid_d;
      s1_px_q    <= s1_px_d;
      s1_last_q  <= s1_last_d;
      s1_user_q  <= s1_user_d;
      s1_mode_q  <= s1_mode_d;
      s1_prod_q  <= s1_prod_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_last_q  <= s2_last_d;
      s2_user_q  <= s2_user_d;
    end
  end

  assign video_i_tready = en;
  assign video_o_tvalid = s2_valid_q;
  assign video_o_tdata  = s2_data_q;
  assign video_o_tlast  = s2_last_q;
  assign video_o_tuser  = s2_user_q;
  assign video_o_tstrb  = '1;
  assign video_o_tkeep  = '1;
  assign video_o_tdest  = 1'b0;
  assign video_o_tid    = 1'b0;
  assign active_mode_o  = mode_q;

  // Sideband inputs and tdata padding carry no meaning for this block.
  logic unused_inputs;
  assign unused_inputs = ^{video_i_tstrb, video_i_tkeep, video_i_tdest, video_i_tid,
                           video_i_tdata};

endmodule

// File: tb/tb_gray_to_color_adapter.sv
module tb_gray_to_color_adapter;

  localparam int PXW = 10;
  localparam int CH  = 3;
  localparam int GW  = 12;
  localparam int GF  = 8;
  localparam logic [35:0] GAIN_DEF = {3{12'd256}};

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  mode_in;
  logic [35:0] gain_in;
  logic        i_tvalid, i_tlast, i_tuser, i_tready;
  logic [15:0] i_tdata;
  logic        o_tvalid, o_tlast, o_tuser, o_tready, o_tdest, o_tid;
  logic [31:0] o_tdata;
  logic [3:0]  o_tstrb, o_tkeep;
  logic [1:0]  active_mode;

  always #5 clk = ~clk;

  gray_to_color_adapter dut (
    .clk_i(clk), .rstn_i(rstn), .mode_i(mode_in), .gain_i(gain_in),
    .video_i_tvalid(i_tvalid), .video_i_tdata(i_tdata), .video_i_tlast(i_tlast),
    .video_i_tuser(i_tuser), .video_i_tstrb(2'b11), .video_i_tkeep(2'b11),
    .video_i_tdest(1'b0), .video_i_tid(1'b0), .video_i_tready(i_tready),
    .video_o_tvalid(o_tvalid), .video_o_tdata(o_tdata), .video_o_tlast(o_tlast),
    .video_o_tuser(o_tuser), .video_o_tstrb(o_tstrb), .video_o_tkeep(o_tkeep),
    .video_o_tdest(o_tdest), .video_o_tid(o_tid), .video_o_tready(o_tready),
    .active_mode_o(active_mode)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [35:0] gain;
    logic [9:0]  px;
    logic        user;
    logic [31:0] exp;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_out = 0;
  bit          chk_lat = 0;
  bit          last_acc = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last, prev_user;
  logic [31:0] got_data;
  logic        got_user;
  int          m_mode = 0;
  logic [35:0] m_gain = GAIN_DEF;

  // Reference: each channel derived straight from the mode rules.
  function automatic logic [31:0] ref_pixel(input int mode, input logic [35:0] gains,
                                            input int px);
    logic [31:0] r;
    int g, v;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      g = int'(gains[c*GW +: GW]);
      if (mode == 1) begin
        v = (px * g) / (1 << GF);
        if (v > (1 << PXW) - 1) v = (1 << PXW) - 1;
      end else if (mode == 2) begin
        v = ((1 << PXW) - 1) - px;
      end else begin
        v = px;
      end
      r = r | (32'(v) << (c * PXW));
    end
    return r;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle: inputs already set after a falling edge.
  task automatic step();
    exp_t e;
    #1;
    cyc++;
    last_acc = 0;
    if (!rstn) begin
      q.delete();
      m_mode = 0;
      m_gain = GAIN_DEF;
      prev_stall = 0;
    end else begin
      chk(i_tready == (!o_tvalid || o_tready), "tready_rule", 64'(i_tready),
          64'(!o_tvalid || o_tready));
      chk(active_mode == 2'(m_mode), "active_mode", 64'(active_mode), 64'(m_mode));
      if (prev_stall) begin
        chk(o_tvalid == 1'b1, "hold_valid", 64'(o_tvalid), 64'd1);
        chk({o_tdata, o_tlast, o_tuser} == {prev_data, prev_last, prev_user}, "hold_data",
            64'({o_tdata, o_tlast, o_tuser}), 64'({prev_data, prev_last, prev_user}));
      end
      if (o_tvalid && o_tready) begin
        n_out++;
        got_data = o_tdata;
        got_user = o_tuser;
        if (q.size() == 0) begin
          chk(0, "spurious_beat", 64'(o_tdata), 64'd0);
        end else begin
          e = q.pop_front();
          chk(o_tdata == e.data, "out_data", 64'(o_tdata), 64'(e.data));
          chk(o_tlast == e.last, "out_last", 64'(o_tlast), 64'(e.last));
          chk(o_tuser == e.user, "out_user", 64'(o_tuser), 64'(e.user));
          if (chk_lat) chk(cyc - e.cyc == 2, "latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
      if (i_tvalid && i_tready) begin
        last_acc = 1;
        if (i_tuser) begin
          m_mode = int'(mode_in);
          m_gain = gain_in;
        end
        e.data = ref_pixel(m_mode, m_gain, int'(i_tdata[PXW-1:0]));
        e.last = i_tlast;
        e.user = i_tuser;
        e.cyc  = cyc;
        q.push_back(e);
      end
      prev_stall = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
      prev_user  = o_tuser;
    end
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [9:0] px, input logic user, input logic last);
    int k;
    k = 0;
    i_tvalid = 1;
    i_tdata  = {6'h2a, px};
    i_tuser  = user;
    i_tlast  = last;
    do begin
      step();
      k++;
    end while (!last_acc && k < 50);
    if (!last_acc) chk(0, "accept_timeout", 64'(k), 64'd50);
    i_tvalid = 0;
  endtask

  task automatic drain(input bit rand_ready);
    int k;
    k = 0;
    i_tvalid = 0;
    while ((q.size() != 0 || o_tvalid) && k < 200) begin
      if (rand_ready) o_tready = ($urandom_range(0, 2) != 0);
      step();
      k++;
    end
    if (q.size() != 0) chk(0, "drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, k, out_before;
    logic [9:0] px;

    vecs[0] = '{2'd0, GAIN_DEF,                        10'h155, 1'b1, 32'h15555555};
    vecs[1] = '{2'd1, {12'd512, 12'd128, 12'd256},     10'h200, 1'b1, 32'h3FF40200};
    vecs[2] = '{2'd0, 36'd0,                           10'h001, 1'b0, 32'h00200001};
    vecs[3] = '{2'd1, {12'd1, 12'd383, 12'd255},       10'h003, 1'b1, 32'h00001002};
    vecs[4] = '{2'd1, {12'd255, 12'd64, 12'd384},      10'h100, 1'b1, 32'h0FF10180};
    vecs[5] = '{2'd2, GAIN_DEF,                        10'h000, 1'b1, 32'h3FFFFFFF};
    vecs[6] = '{2'd0, GAIN_DEF,                        10'h3FF, 1'b0, 32'h00000000};
    vecs[7] = '{2'd3, GAIN_DEF,                        10'h0AB, 1'b1, 32'h0AB2ACAB};

    rstn = 0; mode_in = 0; gain_in = GAIN_DEF;
    i_tvalid = 0; i_tdata = 0; i_tlast = 0; i_tuser = 0; o_tready = 0;
    repeat (3) @(negedge clk);
    rstn = 1;
    #1;
    chk(o_tvalid == 0, "rst_tvalid", 64'(o_tvalid), 64'd0);
    chk(o_tdata == 0, "rst_tdata", 64'(o_tdata), 64'd0);
    chk({o_tlast, o_tuser} == 2'b00, "rst_last_user", 64'({o_tlast, o_tuser}), 64'd0);
    chk(active_mode == 0, "rst_mode", 64'(active_mode), 64'd0);
    chk(i_tready == 1, "rst_tready", 64'(i_tready), 64'd1);
    chk({o_tkeep, o_tstrb} == 8'hFF, "keep_strb", 64'({o_tkeep, o_tstrb}), 64'hFF);
    chk({o_tdest, o_tid} == 2'b00, "dest_id", 64'({o_tdest, o_tid}), 64'd0);

    // Single-beat vectors with latency check.
    o_tready = 1;
    chk_lat = 1;
    for (int i = 0; i < 8; i++) begin
      mode_in = vecs[i].mode;
      gain_in = vecs[i].gain;
      send_beat(vecs[i].px, vecs[i].user, 1'b0);
      drain(0);
      chk(got_data == vecs[i].exp, $sformatf("vec%0d_data", i), 64'(got_data),
          64'(vecs[i].exp));
      chk(got_user == vecs[i].user, $sformatf("vec%0d_user", i), 64'(got_user),
          64'(vecs[i].user));
    end

    // Mode change mid-frame only takes effect at the next start-of-frame.
    mode_in = 0; gain_in = GAIN_DEF;
    send_beat(10'h012, 1'b1, 1'b0);
    mode_in = 2;
    send_beat(10'h021, 1'b0, 1'b0);
    send_beat(10'h034, 1'b0, 1'b1);
    drain(0);
    chk(got_data == 32'h0340D034, "midframe_replicate", 64'(got_data), 64'h0340D034);
    chk(active_mode == 0, "midframe_mode", 64'(active_mode), 64'd0);
    send_beat(10'h034, 1'b1, 1'b0);
    #1;
    chk(active_mode == 2, "sof_mode", 64'(active_mode), 64'd2);
    drain(0);
    chk(got_data == 32'h3CBF2FCB, "sof_invert", 64'(got_data), 64'h3CBF2FCB);

    // Random traffic: two frames of 4 lines x 16 pixels, random valid/ready/config.
    chk_lat = 0;
    sent = 0; k = 0;
    out_before = n_out;
    while (sent < 128 && k < 3000) begin
      if (!i_tvalid && $urandom_range(0, 3) != 0) begin
        px       = 10'($urandom);
        i_tvalid = 1;
        i_tdata  = {6'($urandom), px};
        i_tuser  = (sent % 64 == 0);
        i_tlast  = (sent % 16 == 15);
      end
      o_tready = ($urandom_range(0, 2) != 0);
      mode_in  = 2'($urandom);
      gain_in  = {12'($urandom_range(0, 1023)), 12'($urandom_range(0, 1023)),
                  12'($urandom_range(0, 1023))};
      step();
      k++;
      if (last_acc) begin
        sent++;
        i_tvalid = 0;
      end
    end
    chk(sent == 128, "rand_sent", 64'(sent), 64'd128);
    drain(1);
    chk(n_out - out_before == 128, "rand_beat_count", 64'(n_out - out_before), 64'd128);

    // Reset with two beats in flight.
    o_tready = 1; mode_in = 2; gain_in = {12'd512, 12'd512, 12'd512};
    i_tvalid = 1; i_tuser = 1; i_tlast = 0; i_tdata = 16'h0011;
    step();
    i_tuser = 0; i_tdata = 16'h0022;
    step();
    rstn = 0; i_tvalid = 0; o_tready = 0;
    step();
    rstn = 1;
    #1;
    chk(o_tvalid == 0, "midrst_tvalid", 64'(o_tvalid), 64'd0);
    chk(active_mode == 0, "midrst_mode", 64'(active_mode), 64'd0);
    chk(i_tready == 1, "midrst_tready", 64'(i_tready), 64'd1);
    o_tready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk(o_tvalid == 0, "midrst_no_stale", 64'(o_tvalid), 64'd0);
    end
    // Mode 2 requested but no start-of-frame: replicate still in effect.
    send_beat(10'h0F0, 1'b0, 1'b0);
    drain(0);
    chk(got_data == 32'h0F03C0F0, "post_rst_replicate", 64'(got_data), 64'h0F03C0F0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
